// File: rtl/relu_sched_pkg.sv
// Shared defaults, lane/vector types and FSM state encoding for the ReLU
// issue scheduler.
package relu_sched_pkg;

    localparam int DEF_LANES     = 32;
    localparam int DEF_W         = 16;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_FRAME_LEN = 64;

    typedef logic signed [DEF_W-1:0] lane_t;
    typedef lane_t [DEF_LANES-1:0] vec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/relu_result_fifo.sv
// Result FIFO holding ReLU output vectors with their requester tag.
// Reads are from registered storage, so the head is stable until popped.
module relu_result_fifo #(
    parameter int DW    = 512,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_tag,
    input  logic          pop,
    output logic [DW-1:0] out_data,
    output logic          out_tag,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] data_mem [DEPTH];
    logic          tag_mem  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CW'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[wr_ptr] <= push_data;
            tag_mem[wr_ptr]  <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Gate the head so stale storage never shows after reset or when empty.
    always_comb begin
        out_data = (count != '0) ? data_mem[rd_ptr] : '0;
        out_tag  = (count != '0) ? tag_mem[rd_ptr] : 1'b0;
    end

endmodule

// File: rtl/relu_sched.sv
// Two-requester round-robin scheduler for a shared one-stage ReLU, with a
// credit-limited result FIFO and per-requester frame completion pulses.
module relu_sched
    import relu_sched_pkg::*;
#(
    parameter int LANES     = DEF_LANES,
    parameter int W         = DEF_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [LANES*W-1:0]   req0_data,
    input  logic [LANES*W-1:0]   req1_data,
    output logic                 relu_valid_o,
    output logic [LANES*W-1:0]   relu_data_o,
    input  logic [LANES*W-1:0]   relu_data_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_data,
    output logic                 out_tag,
    output logic [1:0]           frame_done,
    output logic                 busy
);

    localparam int DW = LANES * W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    state_t              state_q;
    state_t              state_d;
    logic                rr_ptr;
    logic                grant_any;
    logic                grant_idx;
    logic                credit;
    logic [CW:0]         occupancy;
    logic                relu_tag;
    logic                cap_valid;
    logic                cap_tag;
    logic                pop;
    logic [CW-1:0]       fifo_count;
    logic [1:0][FW-1:0]  frame_cnt;

    // Credits count everything between grant and pop, all from registers.
    always_comb begin
        occupancy = {1'b0, fifo_count} + (CW+1)'(relu_valid_o) + (CW+1)'(cap_valid);
        credit    = occupancy < (CW+1)'(DEPTH);
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        req_ready = 2'b00;
        if (state_q == ST_RUN && credit) begin
            if (req_valid[rr_ptr]) begin
                grant_any = 1'b1;
                grant_idx = rr_ptr;
            end else if (req_valid[~rr_ptr]) begin
                grant_any = 1'b1;
                grant_idx = ~rr_ptr;
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (stop) state_d = ST_DRAIN;
            ST_DRAIN: if (!relu_valid_o && !cap_valid && fifo_count == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr       <= 1'b0;
            relu_valid_o <= 1'b0;
            relu_data_o  <= '0;
            relu_tag     <= 1'b0;
            cap_valid    <= 1'b0;
            cap_tag      <= 1'b0;
        end else begin
            state_q      <= state_d;
            relu_valid_o <= grant_any;
            if (grant_any) begin
                relu_data_o <= grant_idx ? req1_data : req0_data;
                relu_tag    <= grant_idx;
                rr_ptr      <= ~grant_idx;
            end
            // The ReLU result is valid exactly one cycle after issue.
            cap_valid <= relu_valid_o;
            cap_tag   <= relu_tag;
        end
    end

    relu_result_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cap_valid),
        .push_data (relu_data_i),
        .push_tag  (cap_tag),
        .pop       (pop),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt  <= '0;
            frame_done <= 2'b00;
        end else begin
            frame_done <= 2'b00;
            if (state_q == ST_IDLE && start) begin
                frame_cnt <= '0;
            end else if (pop) begin
                if (frame_cnt[out_tag] == FW'(FRAME_LEN - 1)) begin
                    frame_cnt[out_tag]  <= '0;
                    frame_done[out_tag] <= 1'b1;
                end else begin
                    frame_cnt[out_tag] <= frame_cnt[out_tag] + FW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_relu_sched.sv
// Bench for relu_sched: behavioural one-stage ReLU, scoreboard of expected
// {tag, data} results in issue order, and one task per scenario.
module tb_relu_sched;
    import relu_sched_pkg::*;

    localparam int LANES     = 32;
    localparam int W         = 16;
    localparam int DEPTH     = 4;
    localparam int FRAME_LEN = 4;
    localparam int DW        = LANES * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [DW-1:0] req0_data;
    logic [DW-1:0] req1_data;
    logic          relu_valid_o;
    logic [DW-1:0] relu_data_o;
    logic [DW-1:0] relu_data_i;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_tag;
    logic [1:0]    frame_done;
    logic          busy;

    logic [DW:0]   exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    relu_sched #(
        .LANES     (LANES),
        .W         (W),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req0_data    (req0_data),
        .req1_data    (req1_data),
        .relu_valid_o (relu_valid_o),
        .relu_data_o  (relu_data_o),
        .relu_data_i  (relu_data_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / ReLU model ----------------
    function automatic logic [DW-1:0] relu_fn(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        for (int l = 0; l < LANES; l++) begin
            if (v[l*W + W - 1]) r[l*W +: W] = '0;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*W +: W] = W'($urandom_range(0, 65535));
        return v;
    endfunction

    logic [DW-1:0] relu_q = '0;
    always @(posedge clk) relu_q <= relu_fn(relu_data_o);
    assign relu_data_i = relu_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [DW:0] exp_v;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (req_ready[0] && req_valid[0]) exp_q.push_back({1'b0, relu_fn(req0_data)});
            if (req_ready[1] && req_valid[1]) exp_q.push_back({1'b1, relu_fn(req1_data)});
            n_vec++;
            if (req_ready == 2'b11 || (req_ready & ~req_valid) != 2'b00) begin
                n_err++;
                $display("FAIL grant_legal: req_ready=%b req_valid=%b", req_ready, req_valid);
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra: unexpected output tag=%0d", out_tag);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({out_tag, out_data} !== exp_v) begin
                        n_err++;
                        $display("FAIL sb_data: got %h want %h", {out_tag, out_data}, exp_v);
                    end
                end
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
            step();
            at_neg();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; req_valid = 2'b00; out_ready = 1'b1;
        req0_data = '0; req1_data = '0;
        repeat (3) @(posedge clk);
        at_neg();
        n_vec++;
        if ({busy, req_ready, relu_valid_o, out_valid, out_tag, frame_done} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0", {busy, req_ready, relu_valid_o, out_valid, out_tag, frame_done});
        end
        n_vec++;
        if (relu_data_o !== '0) begin n_err++; $display("FAIL reset_relu_data: got %h want 0", relu_data_o); end
        n_vec++;
        if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        step();
        reset = 1'b0;
        at_neg();
    endtask

    task automatic test_basic();
        vec_t v;
        v = '0;
        v[0] = 16'h1000;
        v[1] = 16'hF000;
        step(); start = 1'b1; at_neg();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
        step(); start = 1'b0; req_valid = 2'b01; req0_data = v; at_neg();
        n_vec++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL basic_ready: got %b want 01", req_ready); end
        step(); req_valid = 2'b00; at_neg();
        n_vec++;
        if (relu_valid_o !== 1'b1 || relu_data_o !== DW'(v) || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_issue: valid=%b out_valid=%b data=%h", relu_valid_o, out_valid, relu_data_o);
        end
        step(); at_neg();
        n_vec++;
        if (relu_valid_o !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_gap: relu_valid=%b out_valid=%b want 0 0", relu_valid_o, out_valid);
        end
        step(); at_neg();
        n_vec++;
        if (out_valid !== 1'b1 || out_data[15:0] !== 16'h1000 || out_data[31:16] !== 16'h0000 || out_tag !== 1'b0) begin
            n_err++;
            $display("FAIL basic_out: valid=%b lane0=%h lane1=%h tag=%b want 1 1000 0000 0",
                     out_valid, out_data[15:0], out_data[31:16], out_tag);
        end
    endtask

    task automatic test_round_robin();
        int g0 = 0;
        int g1 = 0;
        logic have_prev = 1'b0;
        logic prev = 1'b0;
        logic idx;
        for (int c = 0; c < 16; c++) begin
            step();
            req_valid = 2'b11; req0_data = rand_vec(); req1_data = rand_vec();
            at_neg();
            if (req_ready != 2'b00) begin
                idx = req_ready[1];
                if (have_prev) begin
                    n_vec++;
                    if (idx !== ~prev) begin n_err++; $display("FAIL rr_alternate: got %0d want %0d", idx, ~prev); end
                end
                prev = idx; have_prev = 1'b1;
                if (idx) g1++; else g0++;
            end
        end
        step(); req_valid = 2'b00; at_neg();
        n_vec++;
        if (g0 != 8 || g1 != 8) begin n_err++; $display("FAIL rr_fair: grants %0d/%0d want 8/8", g0, g1); end
        wait_drain();
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_drain: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int pops = 0;
        logic seen = 1'b0;
        logic [DW:0] held = '0;
        step(); out_ready = 1'b0; req_valid = 2'b01;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) step();
            req0_data = rand_vec();
            at_neg();
            if (req_ready[0]) acc++;
            if (out_valid) begin
                if (!seen) begin
                    held = {out_tag, out_data}; seen = 1'b1;
                end else begin
                    n_vec++;
                    if ({out_tag, out_data} !== held) begin n_err++; $display("FAIL bp_stable: got %h want %h", {out_tag, out_data}, held); end
                end
            end
        end
        n_vec++;
        if (acc != DEPTH) begin n_err++; $display("FAIL bp_accepted: got %0d want %0d", acc, DEPTH); end
        n_vec++;
        if (req_ready !== 2'b00 || seen !== 1'b1) begin n_err++; $display("FAIL bp_stall: req_ready=%b seen=%b want 00 1", req_ready, seen); end
        step(); req_valid = 2'b00; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            at_neg();
            if (out_valid && out_ready) pops++;
        end
        n_vec++;
        if (pops != DEPTH || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_release: pops=%0d left=%0d want %0d 0", pops, exp_q.size(), DEPTH);
        end
    endtask

    task automatic test_frame();
        int issued = 0;
        int outs = 0;
        int pulses = 0;
        logic exp_pulse = 1'b0;
        step(); stop = 1'b1; at_neg();
        step(); stop = 1'b0; at_neg();
        for (int i = 0; i < 20 && busy; i++) begin step(); at_neg(); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL frame_idle: busy=%b want 0", busy); end
        step(); start = 1'b1; at_neg();
        step(); start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            req_valid = (issued < 8) ? 2'b10 : 2'b00;
            req1_data = rand_vec();
            at_neg();
            if (req_ready[1]) issued++;
            n_vec++;
            if (frame_done !== (exp_pulse ? 2'b10 : 2'b00)) begin
                n_err++;
                $display("FAIL frame_pulse: cycle %0d got %b want %b", c, frame_done, exp_pulse ? 2'b10 : 2'b00);
            end
            if (frame_done[1]) pulses++;
            exp_pulse = out_valid && out_ready && (((outs + 1) % FRAME_LEN) == 0);
            if (out_valid && out_ready) outs++;
            step();
        end
        req_valid = 2'b00;
        at_neg();
        n_vec++;
        if (pulses != 2 || outs != 8) begin n_err++; $display("FAIL frame_count: pulses=%0d outs=%0d want 2 8", pulses, outs); end
    endtask

    task automatic test_stop_drain();
        int acc = 0;
        int bad_grants = 0;
        int pops = 0;
        int last_pop = -1;
        int fell = -1;
        step(); out_ready = 1'b0; start = 1'b1; at_neg();
        step(); start = 1'b0;
        for (int c = 0; c < 10 && acc < 3; c++) begin
            req_valid = 2'b01; req0_data = rand_vec();
            at_neg();
            if (req_ready[0]) acc++;
            step();
        end
        req_valid = 2'b00; stop = 1'b1; at_neg();
        step(); stop = 1'b0; req_valid = 2'b01;
        for (int i = 0; i < 6; i++) begin
            at_neg();
            if (req_ready != 2'b00) bad_grants++;
            step();
        end
        n_vec++;
        if (bad_grants != 0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL drain_hold: grants=%0d busy=%b want 0 1", bad_grants, busy);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            at_neg();
            if (out_valid && out_ready) begin pops++; last_pop = i; end
            if (!busy && fell < 0) fell = i;
            step();
        end
        req_valid = 2'b00;
        at_neg();
        n_vec++;
        if (pops != 3) begin n_err++; $display("FAIL drain_pops: got %0d want 3", pops); end
        n_vec++;
        if (fell != last_pop + 2) begin n_err++; $display("FAIL drain_busy: fell at %0d want %0d", fell, last_pop + 2); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        step(); start = 1'b1; at_neg();
        step(); start = 1'b0; out_ready = 1'b0; req_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            req0_data = rand_vec(); req1_data = rand_vec();
            at_neg();
            step();
        end
        reset = 1'b1; at_neg();
        step(); reset = 1'b0; at_neg();
        n_vec++;
        if ({busy, req_ready, relu_valid_o, out_valid, out_tag, frame_done} !== 8'd0) begin
            n_err++;
            $display("FAIL midreset_ctrl: got %b want 0", {busy, req_ready, relu_valid_o, out_valid, out_tag, frame_done});
        end
        n_vec++;
        if (relu_data_o !== '0 || out_data !== '0) begin
            n_err++;
            $display("FAIL midreset_data: relu=%h out=%h want 0", relu_data_o, out_data);
        end
        step(); req_valid = 2'b00; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            at_neg();
            if (out_valid || frame_done != 2'b00) bad++;
            step();
        end
        at_neg();
        n_vec++;
        if (bad != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL midreset_discard: stray=%0d queued=%0d want 0 0", bad, exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_frame();
        test_stop_drain();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
